// File: rtl/pad_output_driver.sv
`default_nettype none
// ============================================================================
// Module      : pad_output_driver
// Description : Registered output stage feeding an FPGA pad cell. Converts a
//               peripheral's value/enable pair into pad value, pad enable and
//               pad attributes, applying a drive mode (push-pull, open-drain,
//               open-source, force high-Z) and a programmable break-before-make
//               dead time when the push-pull level flips.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i            in   system clock
//   rst_ni           in   asynchronous active-low reset
//   periph_out_i     in   value requested by the peripheral
//   periph_oe_i      in   output enable requested by the peripheral
//   mode_i           in   00 push-pull, 01 open-drain, 10 open-source, 11 high-Z
//   deadtime_i       in   dead-time length in cycles (0 disables)
//   attr_i           in   new pad attribute value
//   attr_we_i        in   attribute write strobe
//   pad_in_o         out  registered pad value
//   pad_oe_o         out  registered pad output enable
//   pad_attributes_o out  registered pad attributes
//   busy_o           out  high while the dead time is running
// ============================================================================
module pad_output_driver #(
    parameter int PADATTR    = 16,
    parameter int DEADTIME_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  periph_out_i,
    input  logic                  periph_oe_i,
    input  logic [1:0]            mode_i,
    input  logic [DEADTIME_W-1:0] deadtime_i,
    input  logic [PADATTR-1:0]    attr_i,
    input  logic                  attr_we_i,
    output logic                  pad_in_o,
    output logic                  pad_oe_o,
    output logic [PADATTR-1:0]    pad_attributes_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        HIZ   = 2'd0,
        DRIVE = 2'd1,
        DEAD  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DEADTIME_W-1:0] cnt;
    logic [DEADTIME_W-1:0] cnt_next;
    logic                  pad_in_next;
    logic                  pad_oe_next;
    logic                  busy_next;
    logic                  req_oe;
    logic                  req_val;

    // Mode translation: open-drain only ever drives low, open-source only
    // ever drives high; the opposite level is represented by releasing the pad.
    always_comb begin
        req_oe  = 1'b0;
        req_val = 1'b0;
        case (mode_i)
            2'b00: begin
                req_oe  = periph_oe_i;
                req_val = periph_out_i;
            end
            2'b01: begin
                req_oe  = periph_oe_i & ~periph_out_i;
                req_val = 1'b0;
            end
            2'b10: begin
                req_oe  = periph_oe_i & periph_out_i;
                req_val = 1'b1;
            end
            default: begin
                req_oe  = 1'b0;
                req_val = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic. The outputs themselves are registered
    // below, so nothing here reaches a port combinationally.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        pad_in_next = pad_in_o;
        pad_oe_next = pad_oe_o;
        busy_next   = 1'b0;
        case (state)
            HIZ: begin
                pad_in_next = req_val;
                if (req_oe) begin
                    state_next  = DRIVE;
                    pad_oe_next = 1'b1;
                end else begin
                    pad_oe_next = 1'b0;
                end
            end
            DRIVE: begin
                if (!req_oe) begin
                    state_next  = HIZ;
                    pad_oe_next = 1'b0;
                end else if (req_val != pad_in_o) begin
                    if (deadtime_i != '0) begin
                        // Release the pad first; the old level stays on
                        // pad_in so only the enable toggles.
                        state_next  = DEAD;
                        pad_oe_next = 1'b0;
                        busy_next   = 1'b1;
                        cnt_next    = deadtime_i - DEADTIME_W'(1);
                    end else begin
                        pad_in_next = req_val;
                    end
                end
            end
            DEAD: begin
                if (!req_oe) begin
                    state_next  = HIZ;
                    pad_oe_next = 1'b0;
                end else if (cnt == '0) begin
                    // Request re-sampled at exit: the latest level wins, even
                    // if it went back to the level driven before the window.
                    state_next  = DRIVE;
                    pad_in_next = req_val;
                    pad_oe_next = 1'b1;
                end else begin
                    cnt_next    = cnt - DEADTIME_W'(1);
                    pad_oe_next = 1'b0;
                    busy_next   = 1'b1;
                end
            end
            default: begin
                state_next  = HIZ;
                pad_oe_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= HIZ;
            cnt      <= '0;
            pad_in_o <= 1'b0;
            pad_oe_o <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            pad_in_o <= pad_in_next;
            pad_oe_o <= pad_oe_next;
            busy_o   <= busy_next;
        end
    end

    // Attribute register is independent of the drive state machine.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pad_attributes_o <= '0;
        end else if (attr_we_i) begin
            pad_attributes_o <= attr_i;
        end
    end

endmodule
`default_nettype wire
